// File: rtl/lfsr_bit_packer_pkg.sv
// Shared constants and state encoding for the LFSR bit packer.
package lfsr_bit_packer_pkg;

  // Seed and feedback taps of the companion 16-bit Fibonacci LFSR (taps 0/2/3/5).
  localparam logic [15:0] SEED_VALUE = 16'hECEB;
  localparam logic [15:0] TAP_MASK   = 16'h002D;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    SAMPLE
  } packer_state_t;

endpackage

// File: rtl/lfsr_bit_packer_if.sv
// Word delivery channel from the packer to its consumer (valid/ready plus occupancy).
interface lfsr_bit_packer_if #(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 4
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WORD_W-1:0] word_rdata;
  logic              word_valid;
  logic              word_ready;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output word_rdata,
    output word_valid,
    output fifo_count,
    input  word_ready
  );

  modport slave (
    input  word_rdata,
    input  word_valid,
    input  fifo_count,
    output word_ready
  );

endinterface

// File: rtl/lfsr_bit_packer_word_fifo.sv
// Synchronous first-word-fall-through FIFO holding packed words.
module word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign count     = count_q;
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  // Write the new entry, advance pointers (wrapping modulo DEPTH) and track occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers; reset discards all queued words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/lfsr_bit_packer.sv
// Paces an external LFSR, packs its bits LSB-first into words and queues them for a consumer.
module lfsr_bit_packer
  import lfsr_bit_packer_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              lfsr_en,
  input  logic              lfsr_bit,
  lfsr_bit_packer_if.master word_if
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int BIT_W = $clog2(WORD_W);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  packer_state_t     state_q, state_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WORD_W-2:0] acc_q, acc_d;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] push_word;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  post_count;

  // The final bit of a word goes straight into the pushed word rather than the accumulator.
  assign push      = (state_q == SAMPLE) && (bit_cnt_q == LAST_BIT);
  assign push_word = {lfsr_bit, acc_q};
  assign pop       = word_if.word_valid && word_if.word_ready;

  word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .head_data (word_if.word_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign word_if.word_valid = !fifo_empty;
  assign word_if.fifo_count = fifo_count;

  // Occupancy the FIFO will hold after this edge, so a new STEP is only issued into a free slot.
  always_comb begin
    post_count = fifo_count;
    if (push && !pop) begin
      post_count = fifo_count + 1'b1;
    end else if (!push && pop) begin
      post_count = fifo_count - 1'b1;
    end
  end

  // STEP/SAMPLE pacing: one enable pulse per bit, sampled the cycle after the LFSR advances.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    acc_d     = acc_q;
    lfsr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (run && !fifo_full) begin
          state_d = STEP;
        end
      end
      STEP: begin
        lfsr_en = 1'b1;
        state_d = SAMPLE;
      end
      SAMPLE: begin
        if (push) begin
          bit_cnt_d = '0;
        end else begin
          acc_d[bit_cnt_q] = lfsr_bit;
          bit_cnt_d        = bit_cnt_q + 1'b1;
        end
        state_d = (run && (post_count < DEPTH_CNT)) ? STEP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, bit counter and partial-word accumulator; a paused word is held here until run returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      acc_q     <= acc_d;
    end
  end

endmodule
